// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams instruction words into CPU memory over AXI-Lite writes.
// Define LOADER_AUTORUN_EN to follow the load with a RUN_VALUE write to CTRL_ADDR.
module prog_loader #(
  parameter logic [31:0] IMEM_BASE = 32'h0000_1000,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
  parameter logic [31:0] RUN_VALUE = 32'h0000_0001,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] loaded
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    RESP
`ifdef LOADER_AUTORUN_EN
    ,
    CTRL,
    CTRL_RESP
`endif
  } state_t;

  state_t      state;
  logic [10:0] count_q;
  logic [10:0] loaded_inc;
  logic        xfer_done;

  assign M_AXI_WSTRB = 4'hF;
  assign loaded_inc  = loaded + 11'd1;
  // Each channel is finished once its valid has dropped or is being accepted now.
  assign xfer_done   = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count_q       <= 11'd0;
      s_ready       <= 1'b0;
      M_AXI_AWADDR  <= 32'd0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'd0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      loaded        <= 11'd0;
    end else begin
      done <= 1'b0;
      if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
      if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            error   <= 1'b0;
            loaded  <= 11'd0;
            count_q <= word_count;
            if ({21'd0, word_count} > MAX_WORDS) begin
              error <= 1'b1;
            end else if (word_count == 11'd0) begin
`ifdef LOADER_AUTORUN_EN
              state         <= CTRL;
              busy          <= 1'b1;
              M_AXI_AWADDR  <= CTRL_ADDR;
              M_AXI_WDATA   <= RUN_VALUE;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
`else
              done <= 1'b1;
`endif
            end else begin
              state   <= FETCH;
              busy    <= 1'b1;
              s_ready <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (s_valid && s_ready) begin
            s_ready       <= 1'b0;
            M_AXI_WDATA   <= s_data;
            M_AXI_AWADDR  <= IMEM_BASE + {19'd0, loaded, 2'b00};
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WRITE;
          end
        end

        WRITE: begin
          if (xfer_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= RESP;
          end
        end

        RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            if (M_AXI_BRESP == 2'b00) begin
              loaded <= loaded_inc;
              if (loaded_inc == count_q) begin
`ifdef LOADER_AUTORUN_EN
                state         <= CTRL;
                M_AXI_AWADDR  <= CTRL_ADDR;
                M_AXI_WDATA   <= RUN_VALUE;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
`else
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end else begin
                state   <= FETCH;
                s_ready <= 1'b1;
              end
            end else begin
              error <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

`ifdef LOADER_AUTORUN_EN
        CTRL: begin
          if (xfer_done) begin
            M_AXI_BREADY <= 1'b1;
            state        <= CTRL_RESP;
          end
        end

        CTRL_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
            if (M_AXI_BRESP == 2'b00) done <= 1'b1;
            else                      error <= 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader.
// Honours LOADER_AUTORUN_EN when forming the expected write list.
module tb_prog_loader;

  localparam logic [31:0] IMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] CTRL_ADDR = 32'h0000_0000;
  localparam logic [31:0] RUN_VALUE = 32'h0000_0001;
  localparam int          MAX_WORDS = 1024;
  localparam int          NONE      = 100000;

  logic        clk, rst_n, start;
  logic [10:0] word_count;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        busy, done, error;
  logic [10:0] loaded;

  prog_loader #(
    .IMEM_BASE(IMEM_BASE), .CTRL_ADDR(CTRL_ADDR), .RUN_VALUE(RUN_VALUE), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .busy(busy), .done(done), .error(error), .loaded(loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [31:0] src_q[$];
  int b_cnt = 0;
  int err_idx = NONE;
  int rdy_mode = 0;
  int stab_viol = 0;
  int done_cnt = 0;
  int done_wide = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // AXI-Lite slave: programmable ready latency, logs accepted addresses/data, answers B.
  initial begin
    bit in_prog = 0, aw_wait = 0, w_wait = 0, b_hs = 0;
    int age = 0, aw_lat = 0, w_lat = 0, wr_idx = 0;
    logic [31:0] aw_prev = 0, w_prev = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_prog = 0; aw_wait = 0; w_wait = 0; b_hs = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
        continue;
      end
      if (aw_wait && (!M_AXI_AWVALID || M_AXI_AWADDR !== aw_prev)) stab_viol++;
      if (w_wait && (!M_AXI_WVALID || M_AXI_WDATA !== w_prev)) stab_viol++;
      if (b_hs) begin
        M_AXI_BVALID = 0;
        b_hs = 0;
      end
      if (!M_AXI_BVALID && aw_log.size() > b_cnt && w_log.size() > b_cnt &&
          (rdy_mode == 0 || $urandom_range(0, 1) == 1)) begin
        M_AXI_BVALID = 1;
        M_AXI_BRESP  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
      end
      b_hs = M_AXI_BVALID && M_AXI_BREADY;
      if (b_hs) b_cnt++;
      if ((M_AXI_AWVALID || M_AXI_WVALID) && !in_prog) begin
        in_prog = 1; age = 0; wr_idx++;
        case (rdy_mode)
          0: begin aw_lat = 0; w_lat = 0; end
          1: begin aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); end
          2: begin aw_lat = wr_idx[0] ? 0 : 2; w_lat = wr_idx[0] ? 2 : 0; end
          default: begin aw_lat = 4; w_lat = 4; end
        endcase
      end else if (!M_AXI_AWVALID && !M_AXI_WVALID) begin
        in_prog = 0;
      end
      M_AXI_AWREADY = in_prog && age >= aw_lat;
      M_AXI_WREADY  = in_prog && age >= w_lat;
      if (in_prog) age++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_log.push_back(M_AXI_AWADDR);
      if (M_AXI_WVALID && M_AXI_WREADY)   w_log.push_back(M_AXI_WDATA);
      aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY; aw_prev = M_AXI_AWADDR;
      w_wait  = M_AXI_WVALID && !M_AXI_WREADY;   w_prev  = M_AXI_WDATA;
    end
  end

  // Word source with random gaps.
  initial begin
    s_valid = 0; s_data = 0;
    forever begin
      @(negedge clk);
      if (rst_n && src_q.size() > 0 && (rdy_mode == 0 || $urandom_range(0, 3) != 0)) begin
        s_valid = 1;
        s_data  = src_q[0];
      end else begin
        s_valid = 0;
      end
      if (s_valid && s_ready) void'(src_q.pop_front());
    end
  end

  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (prev) done_wide++;
      end
      prev = done;
    end
  end

  task automatic run_load(input int cnt, input int err, input int mode, input bit fixed, input bit poke);
    logic [31:0] words[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int nw, exp_ld, cyc, n;
    bit exp_err;
    aw_log.delete(); w_log.delete(); src_q.delete();
    b_cnt = 0; err_idx = err; rdy_mode = mode;
    done_cnt = 0; done_wide = 0; stab_viol = 0;
    if (cnt <= MAX_WORDS)
      for (int i = 0; i < cnt; i++) words.push_back(fixed ? 32'h0000_000A + i : $urandom());
    foreach (words[i]) src_q.push_back(words[i]);
    @(negedge clk);
    start = 1; word_count = cnt[10:0];
    @(negedge clk);
    start = 0;
    if (cnt > MAX_WORDS) check("oversize_err_now", {31'd0, error}, 32'd1);
    cyc = 0;
    while ((busy || poke) && cyc < 20000) begin
      if (poke && M_AXI_AWVALID) begin
        start = 1; word_count = 11'd5;
        @(negedge clk);
        start = 0; poke = 0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check("timeout", {31'd0, cyc >= 20000}, 32'd0);
    repeat (3) @(negedge clk);

    if (cnt > MAX_WORDS) begin
      exp_err = 1; exp_ld = 0; nw = 0;
    end else if (err < cnt) begin
      exp_err = 1; exp_ld = err; nw = err + 1;
    end else begin
      exp_err = 0; exp_ld = cnt; nw = cnt;
    end
    for (int i = 0; i < nw; i++) begin
      exp_addr.push_back(IMEM_BASE + 32'(4 * i));
      exp_data.push_back(words[i]);
    end
`ifdef LOADER_AUTORUN_EN
    if (!exp_err) begin
      exp_addr.push_back(CTRL_ADDR);
      exp_data.push_back(RUN_VALUE);
    end
`endif
    check("aw_count", aw_log.size(), exp_addr.size());
    check("w_count", w_log.size(), exp_data.size());
    n = (aw_log.size() < exp_addr.size()) ? aw_log.size() : exp_addr.size();
    for (int i = 0; i < n; i++) check($sformatf("awaddr[%0d]", i), aw_log[i], exp_addr[i]);
    n = (w_log.size() < exp_data.size()) ? w_log.size() : exp_data.size();
    for (int i = 0; i < n; i++) check($sformatf("wdata[%0d]", i), w_log[i], exp_data[i]);
    check("error", {31'd0, error}, {31'd0, exp_err});
    check("loaded", {21'd0, loaded}, exp_ld);
    check("done_pulses", done_cnt, exp_err ? 0 : 1);
    check("done_width", done_wide, 0);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("stable", stab_viol, 0);
    check("wstrb", {28'd0, M_AXI_WSTRB}, 32'hF);
    src_q.delete();
  endtask

  initial begin
    int cyc, cnt, err;
    rst_n = 0; start = 0; word_count = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_loaded", {21'd0, loaded}, 0);
    check("rst_awvalid", {31'd0, M_AXI_AWVALID}, 0);
    check("rst_sready", {31'd0, s_ready}, 0);
    check("rst_awaddr", M_AXI_AWADDR, 0);
    rst_n = 1;
    @(negedge clk);

    run_load(3, NONE, 0, 1, 0);
    run_load(4, NONE, 2, 0, 0);
    run_load(4, 1, 1, 0, 0);
    run_load(1025, NONE, 0, 0, 0);
    run_load(0, NONE, 0, 0, 0);
    run_load(3, NONE, 1, 0, 1);

    // Reset while the second word's address phase is outstanding.
    aw_log.delete(); w_log.delete(); src_q.delete();
    b_cnt = 0; err_idx = NONE; rdy_mode = 3;
    for (int i = 0; i < 3; i++) src_q.push_back($urandom());
    @(negedge clk);
    start = 1; word_count = 11'd3;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!(M_AXI_AWVALID && aw_log.size() == 1 && w_log.size() == 1) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_wait_timeout", {31'd0, cyc >= 300}, 0);
    #2 rst_n = 0;
    #1;
    check("async_awvalid", {31'd0, M_AXI_AWVALID}, 0);
    check("async_wvalid", {31'd0, M_AXI_WVALID}, 0);
    check("async_awaddr", M_AXI_AWADDR, 0);
    check("async_loaded", {21'd0, loaded}, 0);
    src_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_loaded", {21'd0, loaded}, 0);
    run_load(2, NONE, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      cnt = $urandom_range(1, 12);
      err = ($urandom_range(0, 2) == 0) ? $urandom_range(0, cnt - 1) : NONE;
      run_load(cnt, err, $urandom_range(0, 3), 0, 0);
    end
    run_load(MAX_WORDS, NONE, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_BASE, default 32'h0000_1000: AXI byte address of instruction word 0.
REQ-002 SHALL have parameter CTRL_ADDR, default 32'h0000_0000: AXI address of the CPU control register.
REQ-003 SHALL have parameter RUN_VALUE, default 32'h0000_0001: value written to CTRL_ADDR to start the CPU.
REQ-004 SHALL have parameter MAX_WORDS, default 1024: instruction memory capacity in words.
REQ-005 SHALL have one clock and an asynchronous active-low reset; all other ports are listed in REQ-006 to REQ-011.
  clk  in  1  sole clock; all logic rising-edge.
  rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have command ports:
  start  in  1  one-cycle load request.
  word_count  in  11  number of words to load, sampled with start.
REQ-007 SHALL have word-stream input ports:
  s_valid  in  1  stream word valid.
  s_ready  out  1  stream word accepted when s_valid && s_ready.
  s_data  in  32  instruction word.
REQ-008 SHALL have AXI-Lite master write-address ports:
  M_AXI_AWADDR  out  32  write address.
  M_AXI_AWVALID  out  1  address valid.
  M_AXI_AWREADY  in  1  address ready.
REQ-009 SHALL have AXI-Lite master write-data ports:
  M_AXI_WDATA  out  32  write data.
  M_AXI_WSTRB  out  4  byte strobes; always 4'hF.
  M_AXI_WVALID  out  1  data valid.
  M_AXI_WREADY  in  1  data ready.
REQ-010 SHALL have AXI-Lite master write-response ports:
  M_AXI_BRESP  in  2  write response.
  M_AXI_BVALID  in  1  response valid.
  M_AXI_BREADY  out  1  response ready.
REQ-011 SHALL have status ports:
  busy  out  1  load in progress.
  done  out  1  one-cycle pulse on successful completion.
  error  out  1  sticky until next accepted start.
  loaded  out  11  words acknowledged with OKAY.

Function
REQ-012 SHALL implement states IDLE, FETCH, WRITE, RESP, CTRL, CTRL_RESP.
REQ-013 SHALL, in IDLE, accept start only; start in any other state SHALL be ignored.
REQ-014 SHALL, on an accepted start, clear error and loaded and latch word_count.
REQ-015 SHALL, on start with word_count > MAX_WORDS, set error for that cycle onward and stay IDLE without issuing any AXI transaction.
REQ-016 SHALL, on start with word_count == 0, go directly to the post-load step (REQ-024 or REQ-025).
REQ-017 SHALL assert s_ready only in FETCH; a handshake latches s_data and moves the block to WRITE on the next cycle.
REQ-018 SHALL, in WRITE, drive AWADDR = IMEM_BASE + 4*loaded and WDATA = the latched word, and assert AWVALID and WVALID together.
REQ-019 SHALL drop AWVALID and WVALID independently on their own handshake; AWADDR and WDATA SHALL stay stable while valid is high.
REQ-020 SHALL enter RESP once both AW and W have completed; same-cycle acceptance of both is legal.
REQ-021 SHALL assert BREADY only in RESP and CTRL_RESP.
REQ-022 SHALL, in RESP on BVALID with BRESP==2'b00, increment loaded and go to FETCH, or to the post-load step when loaded reaches the latched count.
REQ-023 SHALL, in RESP or CTRL_RESP on BVALID with BRESP!=0, set error and return to IDLE with no further writes and no done.
REQ-024 SHALL, with the Configuration macro defined, perform the post-load step as: CTRL issues one write of RUN_VALUE to CTRL_ADDR under REQ-018/019 rules, then CTRL_RESP waits for B.
REQ-025 SHALL, with the Configuration macro undefined, perform the post-load step as: return to IDLE, skipping CTRL and CTRL_RESP.
REQ-026 SHALL pulse done for exactly one cycle on return to IDLE without error.
REQ-027 SHALL hold busy high in every state except IDLE.
REQ-028 SHALL apply no timeout; the block waits indefinitely for READY or BVALID.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-transaction, immediately force state IDLE and drive all VALID, READY, busy, done, error, loaded and AWADDR/WDATA outputs to 0.

Configuration
REQ-030 SHALL, when LOADER_AUTORUN_EN is defined, compile in the CTRL/CTRL_RESP start write; when it is undefined, those states SHALL be absent and no CTRL_ADDR write SHALL ever be issued.

Verification
REQ-031 SHALL cover: start, count=3, words A,B,C, slave always ready, OKAY -> writes 0x1000=A, 0x1004=B, 0x1008=C, then 0x0000=1 (autorun), done pulse, loaded=3.
REQ-032 SHALL cover: AWREADY two cycles before WREADY, then the reverse -> each write issued exactly once with AWADDR/WDATA stable throughout.
REQ-033 SHALL cover: count=4 with second B returning BRESP=2'b10 -> error=1, loaded=1, no third write, no ctrl write, no done.
REQ-034 SHALL cover: count=1025 -> error=1 immediately with zero AW transactions; count=0 -> only the ctrl write (autorun) or an immediate done (no autorun).
REQ-035 SHALL cover: rst_n low while AWVALID is high in word 2 -> AWVALID=0 asynchronously; after release busy=0, loaded=0, and a new start reloads from 0x1000.
REQ-036 SHALL cover: start pulsed during WRITE -> ignored, transfer unaffected.
